// File: rtl/sr_config_seq.sv
// Drives one Top_SR configuration transaction: it writes the word twice, checks the second
// readback against the word, retries on a mismatch and aborts when a readback never arrives.
module sr_config_seq #(
  parameter int WIDTH       = 170,
  parameter int DIV_WIDTH   = 6,
  parameter int TMO_WIDTH   = 16,
  parameter int MAX_RETRY   = 3,
  parameter int RETRY_WIDTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   cfg_req,
  input  logic [WIDTH-1:0]       cfg_data,
  input  logic [DIV_WIDTH-1:0]   cfg_div,
  input  logic [TMO_WIDTH-1:0]   timeout,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [1:0]             err_code,
  output logic [RETRY_WIDTH-1:0] retry_cnt,
  output logic                   sr_start,
  output logic [WIDTH-1:0]       sr_din,
  output logic [DIV_WIDTH-1:0]   sr_div,
  input  logic [WIDTH-1:0]       sr_dout,
  input  logic                   sr_valid
);

  // Handshake: cfg_req is a level that is sampled only in IDLE and never queued. sr_start and
  // sr_valid are single-cycle pulses, and sr_valid is honoured only in the WAIT states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR1   = 3'd1,
    WAIT1 = 3'd2,
    WR2   = 3'd3,
    WAIT2 = 3'd4,
    CHECK = 3'd5,
    FIN   = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRY);

  state_t               state;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 match_q;

  logic [TMO_WIDTH:0]   tmo_next;
  logic [TMO_WIDTH-1:0] tmo_sat;
  logic                 tmo_hit;

  // The next count is used so that the FSM leaves on the edge where the count reaches the limit.
  assign tmo_next = {1'b0, tmo_cnt} + {{TMO_WIDTH{1'b0}}, 1'b1};
  assign tmo_sat  = (&tmo_cnt) ? tmo_cnt : tmo_next[TMO_WIDTH-1:0];
  assign tmo_hit  = (timeout != '0) && (tmo_next >= {1'b0, timeout});

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      match_q   <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_code  <= ERR_NONE;
      retry_cnt <= '0;
      sr_start  <= 1'b0;
      sr_din    <= '0;
      sr_div    <= '0;
    end else begin
      sr_start <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_req) begin
            sr_din    <= cfg_data;
            sr_div    <= cfg_div;
            err_code  <= ERR_NONE;
            retry_cnt <= '0;
            cfg_busy  <= 1'b1;
            sr_start  <= 1'b1;
            state     <= WR1;
          end
        end
        WR1: begin
          tmo_cnt <= '0;
          state   <= WAIT1;
        end
        WAIT1: begin
          // This readback is the chip's old content, so it is dropped.
          if (sr_valid) begin
            sr_start <= 1'b1;
            state    <= WR2;
          end else if (tmo_hit) begin
            cfg_busy <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= FIN;
          end else begin
            tmo_cnt <= tmo_sat;
          end
        end
        WR2: begin
          tmo_cnt <= '0;
          state   <= WAIT2;
        end
        WAIT2: begin
          if (sr_valid) begin
            match_q <= (sr_dout == sr_din);
            state   <= CHECK;
          end else if (tmo_hit) begin
            cfg_busy <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= FIN;
          end else begin
            tmo_cnt <= tmo_sat;
          end
        end
        CHECK: begin
          if (match_q) begin
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
            state    <= FIN;
          end else if (retry_cnt < RETRY_LIMIT) begin
            // The failed verify rewrote the word, so a single further write re-checks it.
            retry_cnt <= retry_cnt + 1'b1;
            sr_start  <= 1'b1;
            state     <= WR2;
          end else begin
            cfg_busy <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= ERR_MISMATCH;
            state    <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_config_seq.sv
// Bench for sr_config_seq. A behavioural Top_SR chip model returns the previous contents after
// a programmable delay, and outcomes and timing are predicted from the transaction rules.
module tb_sr_config_seq;

  localparam int W  = 170;
  localparam int DW = 6;
  localparam int TW = 16;
  localparam int RW = 2;
  localparam int MAX_RETRY = 3;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_req = 1'b0;
  logic [W-1:0]  cfg_data = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [TW-1:0] timeout = '0;
  logic          cfg_busy, cfg_done, cfg_err, sr_start;
  logic [1:0]    err_code;
  logic [RW-1:0] retry_cnt;
  logic [W-1:0]  sr_din;
  logic [DW-1:0] sr_div;
  logic [W-1:0]  sr_dout = '0;
  logic          sr_valid = 1'b0;

  sr_config_seq #(.WIDTH(W), .DIV_WIDTH(DW), .TMO_WIDTH(TW), .MAX_RETRY(MAX_RETRY),
                  .RETRY_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst(rst), .cfg_req(cfg_req), .cfg_data(cfg_data), .cfg_div(cfg_div),
    .timeout(timeout), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .err_code(err_code), .retry_cnt(retry_cnt), .sr_start(sr_start), .sr_din(sr_din),
    .sr_div(sr_div), .sr_dout(sr_dout), .sr_valid(sr_valid)
  );

  always #5 clk_in = ~clk_in;

  int t_edge = 0;
  always @(posedge clk_in) t_edge <= t_edge + 1;

  int n_vec = 0;
  int n_err = 0;

  // Chip model knobs, set by the test tasks.
  int m_delay = 4;
  int m_corrupt_n = 0;
  bit m_never_valid = 1'b0;
  bit m_force_wr = 1'b0;
  int txn_id = 0;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } pend_t;
  pend_t pend_q[$];

  logic [W-1:0]  chip = '0;
  logic [W-1:0]  rb;
  int            seen_txn = -1;
  int            start_idx = 0;
  int            start_t[$];
  int            done_cnt = 0;
  int            err_cnt = 0;
  int            chg_cnt = 0;
  int            busy_bad = 0;
  bit            prev_busy = 1'b0;
  logic [W-1:0]  prev_din = '0;
  logic [DW-1:0] prev_div = '0;

  // Chip model and monitor, both evaluated mid-cycle.
  always @(negedge clk_in) begin
    sr_valid = 1'b0;
    if (!rst) pend_q.delete();
    if (pend_q.size() > 0 && pend_q[0].due == t_edge) begin
      sr_valid = 1'b1;
      sr_dout  = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    if (rst && sr_start) begin
      if (txn_id != seen_txn) begin
        seen_txn  = txn_id;
        start_idx = 0;
      end
      start_idx++;
      start_t.push_back(t_edge);
      rb   = chip;
      chip = sr_din;
      if (start_idx >= 2 && start_idx - 1 <= m_corrupt_n) rb[0] = ~rb[0];
      if (!m_never_valid) pend_q.push_back('{t_edge + m_delay, rb});
      if (m_force_wr) begin
        sr_valid = 1'b1;
        sr_dout  = ~sr_din;
      end
    end
    if (cfg_done) begin
      done_cnt++;
      if (cfg_busy) busy_bad++;
    end
    if (cfg_err) begin
      err_cnt++;
      if (cfg_busy) busy_bad++;
    end
    if (cfg_busy && prev_busy && (sr_din != prev_din || sr_div != prev_div)) chg_cnt++;
    prev_busy = cfg_busy;
    prev_din  = sr_din;
    prev_div  = sr_div;
  end

  // Observations from the most recent do_txn.
  int            obs_acc_t, obs_fin_t, obs_done, obs_err, obs_starts, obs_chg, obs_bb;
  int            obs_st[8];
  logic          obs_busy_acc, obs_busy_post;
  logic [1:0]    obs_code;
  logic [RW-1:0] obs_retry;
  logic [W-1:0]  obs_din;
  logic [DW-1:0] obs_div;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < 6; i++) w = {w[W-33:0], 32'($urandom())};
    return w;
  endfunction

  // Expected time of the idx-th write pulse when every readback arrives d cycles after its start.
  function automatic int exp_start(int idx, int acc, int d);
    if (idx == 0) return acc;
    return acc + d + 1 + (idx - 1) * (d + 2);
  endfunction

  task automatic do_txn(input logic [W-1:0] data, input logic [DW-1:0] div, input int d,
                        input int corrupt_n, input logic [TW-1:0] tmo, input bit never_valid,
                        input bit force_wr, input bit extra_req, input int budget);
    int base_s, base_d, base_e, base_c, base_v;
    m_delay = d;
    m_corrupt_n = corrupt_n;
    m_never_valid = never_valid;
    m_force_wr = force_wr;
    timeout = tmo;
    base_s = start_t.size();
    base_d = done_cnt;
    base_e = err_cnt;
    base_c = chg_cnt;
    base_v = busy_bad;
    txn_id++;
    @(negedge clk_in); #1;
    cfg_req = 1'b1;
    cfg_data = data;
    cfg_div = div;
    @(posedge clk_in); #1;
    cfg_req = 1'b0;
    obs_acc_t = t_edge;
    obs_busy_acc = cfg_busy;
    obs_fin_t = -1;
    obs_code = '0;
    obs_retry = '0;
    obs_din = '0;
    obs_div = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in); #1;
      if (extra_req && i == 1) begin
        cfg_req = 1'b1;
        cfg_data = ~data;
        cfg_div = ~div;
      end else begin
        cfg_req = 1'b0;
      end
      if (done_cnt != base_d || err_cnt != base_e) begin
        obs_fin_t = t_edge;
        obs_code = err_code;
        obs_retry = retry_cnt;
        obs_din = sr_din;
        obs_div = sr_div;
        break;
      end
    end
    if (extra_req && obs_fin_t >= 0) cfg_req = 1'b1;
    @(negedge clk_in); #1;
    cfg_req = 1'b0;
    obs_busy_post = cfg_busy;
    repeat (3) @(negedge clk_in);
    #1;
    obs_done = done_cnt - base_d;
    obs_err = err_cnt - base_e;
    obs_starts = start_t.size() - base_s;
    for (int i = 0; i < 8; i++) obs_st[i] = (i < obs_starts) ? start_t[base_s + i] : -1;
    obs_chg = chg_cnt - base_c;
    obs_bb = busy_bad - base_v;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", cfg_busy); end
    n_vec++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b exp 0", cfg_done); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", cfg_err); end
    n_vec++; if (err_code !== 2'd0) begin n_err++; $display("FAIL reset_code: got %0d exp 0", err_code); end
    n_vec++; if (retry_cnt !== '0) begin n_err++; $display("FAIL reset_retry: got %0d exp 0", retry_cnt); end
    n_vec++; if (sr_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b exp 0", sr_start); end
    n_vec++; if (sr_din !== '0) begin n_err++; $display("FAIL reset_din: got %h exp 0", sr_din); end
    n_vec++; if (sr_div !== '0) begin n_err++; $display("FAIL reset_div: got %0d exp 0", sr_div); end
    @(negedge clk_in); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_basic();
    logic [W-1:0] word;
    word = {1'b1, 169'b1011};
    do_txn(word, 6'd1, 4, 0, 16'd0, 1'b0, 1'b0, 1'b0, 60);
    n_vec++; if (obs_busy_acc !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b exp 1", obs_busy_acc); end
    n_vec++; if (obs_starts != 2) begin n_err++; $display("FAIL basic_starts: got %0d exp 2", obs_starts); end
    n_vec++; if (obs_st[1] != exp_start(1, obs_acc_t, 4)) begin n_err++; $display("FAIL basic_start2_t: got %0d exp %0d", obs_st[1], exp_start(1, obs_acc_t, 4)); end
    n_vec++; if (obs_fin_t != obs_acc_t + 11) begin n_err++; $display("FAIL basic_fin_t: got %0d exp %0d", obs_fin_t, obs_acc_t + 11); end
    n_vec++; if (obs_done != 1 || obs_err != 0) begin n_err++; $display("FAIL basic_pulses: got done=%0d err=%0d exp 1/0", obs_done, obs_err); end
    n_vec++; if (obs_code !== 2'd0 || obs_retry !== '0) begin n_err++; $display("FAIL basic_code: got code=%0d retry=%0d exp 0/0", obs_code, obs_retry); end
    n_vec++; if (obs_div !== 6'd1 || obs_chg != 0) begin n_err++; $display("FAIL basic_div: got div=%0d chg=%0d exp 1/0", obs_div, obs_chg); end
    n_vec++; if (obs_din !== word) begin n_err++; $display("FAIL basic_din: got %h exp %h", obs_din, word); end
    n_vec++; if (obs_bb != 0) begin n_err++; $display("FAIL basic_busy_fin: got %0d exp 0", obs_bb); end
  endtask

  task automatic test_retry_once();
    do_txn(rand_word(), 6'd5, 3, 1, 16'd0, 1'b0, 1'b0, 1'b0, 80);
    n_vec++; if (obs_starts != 3) begin n_err++; $display("FAIL retry1_starts: got %0d exp 3", obs_starts); end
    n_vec++; if (obs_st[2] != exp_start(2, obs_acc_t, 3)) begin n_err++; $display("FAIL retry1_start3_t: got %0d exp %0d", obs_st[2], exp_start(2, obs_acc_t, 3)); end
    n_vec++; if (obs_done != 1 || obs_err != 0) begin n_err++; $display("FAIL retry1_pulses: got done=%0d err=%0d exp 1/0", obs_done, obs_err); end
    n_vec++; if (obs_retry !== 2'd1 || obs_code !== 2'd0) begin n_err++; $display("FAIL retry1_cnt: got retry=%0d code=%0d exp 1/0", obs_retry, obs_code); end
  endtask

  task automatic test_retry_exhaust();
    do_txn(rand_word(), 6'd9, 2, 99, 16'd0, 1'b0, 1'b0, 1'b0, 120);
    n_vec++; if (obs_starts != 2 + MAX_RETRY) begin n_err++; $display("FAIL exhaust_starts: got %0d exp %0d", obs_starts, 2 + MAX_RETRY); end
    n_vec++; if (obs_done != 0 || obs_err != 1) begin n_err++; $display("FAIL exhaust_pulses: got done=%0d err=%0d exp 0/1", obs_done, obs_err); end
    n_vec++; if (obs_code !== 2'd1 || obs_retry !== 2'd3) begin n_err++; $display("FAIL exhaust_code: got code=%0d retry=%0d exp 1/3", obs_code, obs_retry); end
    n_vec++; if (obs_fin_t != exp_start(4, obs_acc_t, 2) + 4) begin n_err++; $display("FAIL exhaust_fin_t: got %0d exp %0d", obs_fin_t, exp_start(4, obs_acc_t, 2) + 4); end
  endtask

  task automatic test_timeout();
    do_txn(rand_word(), 6'd3, 4, 0, 16'd20, 1'b1, 1'b0, 1'b0, 60);
    n_vec++; if (obs_starts != 1) begin n_err++; $display("FAIL tmo_starts: got %0d exp 1", obs_starts); end
    n_vec++; if (obs_fin_t - obs_st[0] != 21) begin n_err++; $display("FAIL tmo_latency: got %0d exp 21", obs_fin_t - obs_st[0]); end
    n_vec++; if (obs_err != 1 || obs_done != 0 || obs_code !== 2'd2) begin n_err++; $display("FAIL tmo_err: got err=%0d done=%0d code=%0d exp 1/0/2", obs_err, obs_done, obs_code); end
  endtask

  task automatic test_timeout_off();
    do_txn(rand_word(), 6'd3, 4, 0, 16'd0, 1'b1, 1'b0, 1'b0, 150);
    n_vec++; if (obs_fin_t != -1 || obs_err != 0) begin n_err++; $display("FAIL tmo_off_end: got fin=%0d err=%0d exp -1/0", obs_fin_t, obs_err); end
    n_vec++; if (cfg_busy !== 1'b1) begin n_err++; $display("FAIL tmo_off_busy: got %b exp 1", cfg_busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    rst = 1'b1;
    n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL tmo_off_abort: got %b exp 0", cfg_busy); end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] word;
    word = rand_word();
    do_txn(word, 6'd12, 3, 0, 16'd0, 1'b0, 1'b1, 1'b1, 60);
    n_vec++; if (obs_starts != 2) begin n_err++; $display("FAIL ignore_starts: got %0d exp 2", obs_starts); end
    n_vec++; if (obs_fin_t != exp_start(1, obs_acc_t, 3) + 5) begin n_err++; $display("FAIL ignore_fin_t: got %0d exp %0d", obs_fin_t, exp_start(1, obs_acc_t, 3) + 5); end
    n_vec++; if (obs_done != 1 || obs_err != 0) begin n_err++; $display("FAIL ignore_pulses: got done=%0d err=%0d exp 1/0", obs_done, obs_err); end
    n_vec++; if (obs_din !== word || obs_chg != 0) begin n_err++; $display("FAIL ignore_din: got %h chg=%0d exp %h", obs_din, obs_chg, word); end
    n_vec++; if (obs_busy_post !== 1'b0) begin n_err++; $display("FAIL ignore_fin_req: got busy=%b exp 0", obs_busy_post); end
  endtask

  task automatic test_reset_mid();
    int base_s, base_d, base_e, k;
    m_delay = 6;
    m_corrupt_n = 0;
    m_never_valid = 1'b0;
    m_force_wr = 1'b0;
    timeout = '0;
    base_s = start_t.size();
    base_d = done_cnt;
    base_e = err_cnt;
    txn_id++;
    @(negedge clk_in); #1;
    cfg_req = 1'b1;
    cfg_data = rand_word();
    @(posedge clk_in); #1;
    cfg_req = 1'b0;
    k = 0;
    while (start_t.size() < base_s + 2 && k < 50) begin
      @(negedge clk_in); #1;
      k++;
    end
    n_vec++; if (k >= 50) begin n_err++; $display("FAIL rmid_wr2: got no second start in %0d cycles", k); end
    @(negedge clk_in); #1;
    rst = 1'b0;
    @(posedge clk_in); #1;
    n_vec++; if ({cfg_busy, cfg_done, cfg_err, sr_start} !== 4'b0) begin n_err++; $display("FAIL rmid_ctl: got %b exp 0000", {cfg_busy, cfg_done, cfg_err, sr_start}); end
    n_vec++; if (sr_din !== '0 || sr_div !== '0 || err_code !== '0 || retry_cnt !== '0) begin n_err++; $display("FAIL rmid_data: got din=%h div=%0d code=%0d retry=%0d exp 0", sr_din, sr_div, err_code, retry_cnt); end
    @(negedge clk_in);
    @(negedge clk_in); #1;
    rst = 1'b1;
    repeat (12) @(negedge clk_in);
    #1;
    n_vec++; if (done_cnt != base_d || err_cnt != base_e) begin n_err++; $display("FAIL rmid_pulse: got done=%0d err=%0d exp 0/0", done_cnt - base_d, err_cnt - base_e); end
    do_txn(rand_word(), 6'd7, 2, 0, 16'd0, 1'b0, 1'b0, 1'b0, 60);
    n_vec++; if (obs_done != 1 || obs_fin_t != exp_start(1, obs_acc_t, 2) + 4) begin n_err++; $display("FAIL rmid_after: got done=%0d fin=%0d exp 1/%0d", obs_done, obs_fin_t, exp_start(1, obs_acc_t, 2) + 4); end
  endtask

  task automatic test_random();
    int d, c, tmo, e_starts, e_fin, e_done, e_retry;
    logic [1:0] e_code;
    logic [W-1:0] word;
    for (int it = 0; it < 12; it++) begin
      d = $urandom_range(1, 8);
      c = $urandom_range(0, 5);
      tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 10);
      word = rand_word();
      do_txn(word, DW'($urandom()), d, c, TW'(tmo), 1'b0, 1'b0, 1'b0, 200);
      // The timeout fires in the first wait whenever the readback is later than the limit.
      if (tmo != 0 && tmo < d) begin
        e_starts = 1; e_done = 0; e_code = 2'd2; e_retry = 0; e_fin = obs_acc_t + tmo + 1;
      end else if (c <= MAX_RETRY) begin
        e_starts = 2 + c; e_done = 1; e_code = 2'd0; e_retry = c;
        e_fin = exp_start(e_starts - 1, obs_acc_t, d) + d + 2;
      end else begin
        e_starts = 2 + MAX_RETRY; e_done = 0; e_code = 2'd1; e_retry = MAX_RETRY;
        e_fin = exp_start(e_starts - 1, obs_acc_t, d) + d + 2;
      end
      n_vec++; if (obs_starts != e_starts) begin n_err++; $display("FAIL rand%0d_starts: got %0d exp %0d", it, obs_starts, e_starts); end
      n_vec++; if (obs_fin_t != e_fin) begin n_err++; $display("FAIL rand%0d_fin_t: got %0d exp %0d", it, obs_fin_t, e_fin); end
      n_vec++; if (obs_done != e_done || obs_err != 1 - e_done) begin n_err++; $display("FAIL rand%0d_pulses: got done=%0d err=%0d exp %0d/%0d", it, obs_done, obs_err, e_done, 1 - e_done); end
      n_vec++; if (obs_code !== e_code || obs_retry !== RW'(e_retry)) begin n_err++; $display("FAIL rand%0d_code: got code=%0d retry=%0d exp %0d/%0d", it, obs_code, obs_retry, e_code, e_retry); end
      n_vec++; if (obs_din !== word || obs_chg != 0 || obs_bb != 0) begin n_err++; $display("FAIL rand%0d_hold: got din=%h chg=%0d bb=%0d exp %h/0/0", it, obs_din, obs_chg, obs_bb, word); end
      for (int i = 1; i < e_starts && i < 8; i++) begin
        n_vec++; if (obs_st[i] != exp_start(i, obs_acc_t, d)) begin n_err++; $display("FAIL rand%0d_start%0d_t: got %0d exp %0d", it, i, obs_st[i], exp_start(i, obs_acc_t, d)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry_once();
    test_retry_exhaust();
    test_timeout();
    test_timeout_off();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr_config_seq.md
Name: sr_config_seq

Overview:
- Sequencer that drives the Top_SR serial shift-register write/readback path for one configuration transaction.
- Writes a WIDTH-bit configuration word into the on-chip shift register twice. The readback from the second write must equal the first word, which verifies that the chip holds it.
- Retries on mismatch and times out on a missing valid.
- Sits between the host/register-file side and Top_SR, in the clk_in domain.

Parameters:
- WIDTH, 170, shift-register / configuration word length in bits
- DIV_WIDTH, 6, width of the serial-clock divider setting passed to Top_SR
- TMO_WIDTH, 16, width of the timeout counter and timeout input
- MAX_RETRY, 3, extra write/verify attempts after the first mismatch
- RETRY_WIDTH, 2, width of retry_cnt; must hold MAX_RETRY

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- cfg_req  input  1  request to start a transaction; sampled only in IDLE
- cfg_data  input  WIDTH  configuration word, latched on accept
- cfg_div  input  DIV_WIDTH  serial divider setting, latched on accept
- timeout  input  TMO_WIDTH  max clk_in cycles from sr_start to sr_valid; 0 disables
- cfg_busy  output  1  high from the cycle after accept until done/error
- cfg_done  output  1  one-cycle pulse: verify passed
- cfg_err  output  1  one-cycle pulse: transaction failed
- err_code  output  2  0 none, 1 verify mismatch after all retries, 2 timeout; held until next accept
- retry_cnt  output  RETRY_WIDTH  retries used in current/last transaction
- sr_start  output  1  one-cycle start pulse to Top_SR
- sr_din  output  WIDTH  word to shift in (latched cfg_data)
- sr_div  output  DIV_WIDTH  latched cfg_div
- sr_dout  input  WIDTH  word shifted out by Top_SR
- sr_valid  input  1  one-cycle pulse in clk_in domain: sr_dout valid, shift complete

Behaviour:
- Reset (rst=0 at a clock edge) has priority over everything. All outputs are 0, state is IDLE, timeout counter 0, latched data/div 0. Reset mid-transaction aborts it; no done or err pulse is issued.
- States: IDLE, WR1, WAIT1, WR2, WAIT2, CHECK, FIN.
- IDLE: cfg_req=1 at edge N latches cfg_data and cfg_div, clears err_code and retry_cnt, and goes to WR1.
  - cfg_busy=1 from N+1.
  - cfg_req in any state other than IDLE is ignored, with no queuing.
- WR1: sr_start=1 for exactly this one cycle, then WAIT1. The timeout counter clears on entry.
- WAIT1:
  - sr_valid=1 → WR2. sr_dout is discarded because it holds the previous chip content.
  - Otherwise, if timeout≠0 and the counter reaches timeout → FIN with error code 2.
- WR2: identical to WR1 (one-cycle sr_start, counter clear), then WAIT2.
- WAIT2: sr_valid=1 registers compare result (sr_dout == latched word) → CHECK. Timeout is handled as in WAIT1.
- sr_valid arriving in a WR cycle (the same cycle as sr_start) is ignored.
- CHECK:
  - Match → FIN with success.
  - Mismatch and retry_cnt < MAX_RETRY → retry_cnt+1, go to WR2. The chip now holds the word again, so one further write suffices.
  - Mismatch and retry_cnt = MAX_RETRY → FIN with error code 1.
- FIN: exactly one of cfg_done or cfg_err pulses for one cycle, cfg_busy=0 in that same cycle, then IDLE. A cfg_req sampled in FIN is ignored.
- sr_din and sr_div are stable for the whole busy window and change only on accept.
- Timeout counter: saturating, TMO_WIDTH bits, counts clk_in cycles in the WAIT states.
- Comparison is full WIDTH, bit-exact, unsigned equality.
- Minimum latency, with sr_valid arriving 1 cycle after each sr_start and a match: accept N, sr_start N+1 and N+3, CHECK N+5, cfg_done N+6.

Test Plan:
- Bench SR model returns the previous word 4 cycles after sr_start. Write cfg_data={1'b1,169'b1011}, cfg_div=1 → two sr_start pulses, cfg_done once, err_code=0, retry_cnt=0, sr_div=1 throughout busy.
- Model corrupts bit 0 on the first verify only → third sr_start issued, cfg_done, retry_cnt=1.
- Model always corrupts the readback → 2+MAX_RETRY=5 sr_start pulses total, cfg_err pulse, err_code=1, retry_cnt=3.
- timeout=20 and model never asserts sr_valid → cfg_err exactly 21 cycles after the first sr_start cycle, err_code=2; with timeout=0 busy stays high indefinitely.
- Second cfg_req with different data while busy → ignored; sr_din unchanged; only one done pulse. sr_valid forced in a WR cycle → ignored.
- rst=0 during WAIT2 → next cycle all outputs 0, no done/err pulse; a new cfg_req afterwards completes normally.
